// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR register file for a single-hart core.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   csr_addr, csr_wdata - CSR address and operand of the current instruction
//   csr_op              - 00 none, 01 write, 10 set, 11 clear
//   csr_rdata           - combinational pre-write value of the addressed CSR
//   illegal_csr         - combinational: access to an unimplemented CSR or a
//                         write-type access to mhartid
//   trap_valid, trap_cause, trap_pc, trap_val - trap entry request and data
//   mret                - mret retires this cycle
//   instr_retire        - one instruction retires this cycle (minstret)
//   trap_vector, epc    - registered {mtvec[31:2],2'b00} and mepc
//
// Parameter MTVEC_RESET sets the mtvec reset value (low two bits forced to 0).
// Optional macro CSR_COUNTERS_EN adds 64-bit mcycle/minstret counters at
// 0xB00/0xB80 and 0xB02/0xB82; without it those addresses are unimplemented.
`timescale 1ns/1ps
module csr_regfile #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  csr_op,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        instr_retire,
    output logic [31:0] trap_vector,
    output logic [31:0] epc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

    // Architectural state; mtvec and mepc keep only their aligned upper bits.
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:2] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
`ifdef CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
`endif

    logic [31:0] w_rdata;
    logic        w_impl;
    logic        w_illegal;
    logic [31:0] w_new;
    logic        w_wr;

    // Read mux: decodes csr_addr into the current value and an implemented flag.
    always_comb begin
        w_rdata = 32'h0000_0000;
        w_impl  = 1'b1;
        case (csr_addr)
            A_MSTATUS:   w_rdata = {19'h0_0000, 2'b11, 3'b000, r_mstatus_mpie,
                                    3'b000, r_mstatus_mie, 3'b000};
            A_MIE:       w_rdata = r_mie;
            A_MTVEC:     w_rdata = {r_mtvec, 2'b00};
            A_MSCRATCH:  w_rdata = r_mscratch;
            A_MEPC:      w_rdata = {r_mepc, 2'b00};
            A_MCAUSE:    w_rdata = r_mcause;
            A_MTVAL:     w_rdata = r_mtval;
            A_MHARTID:   w_rdata = 32'h0000_0000;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    w_rdata = r_mcycle[31:0];
            A_MCYCLEH:   w_rdata = r_mcycle[63:32];
            A_MINSTRET:  w_rdata = r_minstret[31:0];
            A_MINSTRETH: w_rdata = r_minstret[63:32];
`endif
            default: begin
                w_rdata = 32'h0000_0000;
                w_impl  = 1'b0;
            end
        endcase
    end

    // Read-modify-write value computed from the pre-write read data.
    always_comb begin
        w_new = w_rdata;
        case (csr_op)
            2'b01:   w_new = csr_wdata;
            2'b10:   w_new = w_rdata | csr_wdata;
            2'b11:   w_new = w_rdata & ~csr_wdata;
            default: w_new = w_rdata;
        endcase
    end

    // A CSR write only commits when legal and not pre-empted by trap or mret.
    assign w_illegal   = (csr_op != 2'b00) && (!w_impl || (csr_addr == A_MHARTID));
    assign w_wr        = (csr_op != 2'b00) && !w_illegal && !trap_valid && !mret;
    assign csr_rdata   = w_rdata;
    assign illegal_csr = w_illegal;
    assign trap_vector = {r_mtvec, 2'b00};
    assign epc         = {r_mepc, 2'b00};

    // Core CSR state: trap entry beats mret, which beats a software write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'h0000_0000;
            r_mtvec        <= MTVEC_RESET[31:2];
            r_mscratch     <= 32'h0000_0000;
            r_mepc         <= 30'h0000_0000;
            r_mcause       <= 32'h0000_0000;
            r_mtval        <= 32'h0000_0000;
        end else if (trap_valid) begin
            r_mepc         <= trap_pc[31:2];
            r_mcause       <= trap_cause;
            r_mtval        <= trap_val;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr) begin
            case (csr_addr)
                A_MSTATUS: begin
                    r_mstatus_mie  <= w_new[3];
                    r_mstatus_mpie <= w_new[7];
                end
                A_MIE:      r_mie      <= w_new;
                A_MTVEC:    r_mtvec    <= w_new[31:2];
                A_MSCRATCH: r_mscratch <= w_new;
                A_MEPC:     r_mepc     <= w_new[31:2];
                A_MCAUSE:   r_mcause   <= w_new;
                A_MTVAL:    r_mtval    <= w_new;
                default:    r_mscratch <= r_mscratch;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // Counters: a write to either half replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            if (w_wr && (csr_addr == A_MCYCLE))
                r_mcycle <= {r_mcycle[63:32], w_new};
            else if (w_wr && (csr_addr == A_MCYCLEH))
                r_mcycle <= {w_new, r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wr && (csr_addr == A_MINSTRET))
                r_minstret <= {r_minstret[63:32], w_new};
            else if (w_wr && (csr_addr == A_MINSTRETH))
                r_minstret <= {w_new, r_minstret[31:0]};
            else if (instr_retire)
                r_minstret <= r_minstret + 64'd1;
            else
                r_minstret <= r_minstret;
        end
    end
`else
    // Retire strobe has no consumer when counters are not built.
    logic w_unused_retire;
    assign w_unused_retire = instr_retire;
`endif

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile.
`timescale 1ns/1ps
module tb_csr_regfile;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret;
    logic        instr_retire;
    logic [31:0] trap_vector;
    logic [31:0] epc;

    int n_cmp;
    int n_mis;

    csr_regfile #(.MTVEC_RESET(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_op       (csr_op),
        .csr_rdata    (csr_rdata),
        .illegal_csr  (illegal_csr),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_val     (trap_val),
        .mret         (mret),
        .instr_retire (instr_retire),
        .trap_vector  (trap_vector),
        .epc          (epc)
    );

    // Free-running clock, 100 ns period.
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_acc(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = d;
        tick();
        csr_op    = 2'b00;
        csr_wdata = 32'h0000_0000;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_op   = 2'b00;
        csr_addr = a;
        #1;
        check_eq(tag, csr_rdata, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        csr_addr = 12'h341; csr_wdata = 32'h0; csr_op = 2'b00;
        trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_val = 32'h0;
        mret = 1'b0; instr_retire = 1'b0;

        // Reset state
        #10;
        check_eq("rst_mepc_rd", csr_rdata, 32'h0000_0000);
        check_eq("rst_illegal", {31'h0, illegal_csr}, 32'h0);
        check_eq("rst_trap_vector", trap_vector, 32'h0000_0000);
        check_eq("rst_epc", epc, 32'h0000_0000);
        #10 rst_n = 1'b1;
        tick();
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);

        // mtvec alignment
        csr_addr = 12'h305; csr_op = 2'b01; csr_wdata = 32'h8000_0103;
        #1 check_eq("mtvec_wr_legal", {31'h0, illegal_csr}, 32'h0);
        tick();
        csr_op = 2'b00;
        rd_chk("mtvec_rd", 12'h305, 32'h8000_0100);
        check_eq("trap_vector", trap_vector, 32'h8000_0100);

        // mscratch write / set / clear
        csr_acc(12'h340, 2'b01, 32'hF0F0_F0F0);
        rd_chk("mscratch_wr", 12'h340, 32'hF0F0_F0F0);
        csr_acc(12'h340, 2'b10, 32'h0000_000F);
        rd_chk("mscratch_set", 12'h340, 32'hF0F0_F0FF);
        csr_acc(12'h340, 2'b11, 32'h0000_00F0);
        rd_chk("mscratch_clr", 12'h340, 32'hF0F0_F00F);

        // mstatus field masking, then MIE=1
        csr_acc(12'h300, 2'b01, 32'hFFFF_FFFF);
        rd_chk("mstatus_ones", 12'h300, 32'h0000_1888);
        csr_acc(12'h300, 2'b01, 32'h0000_0008);
        rd_chk("mstatus_mie", 12'h300, 32'h0000_1808);

        // mie full width
        csr_acc(12'h304, 2'b01, 32'hABCD_1234);
        rd_chk("mie_rd", 12'h304, 32'hABCD_1234);

        // Trap with a simultaneous mepc write: trap wins
        csr_addr = 12'h341; csr_op = 2'b01; csr_wdata = 32'h0000_5678;
        trap_valid = 1'b1; trap_pc = 32'h0000_1006; trap_cause = 32'h0000_000B;
        trap_val = 32'hDEAD_BEEF;
        #1 check_eq("epc_not_bypassed", epc, 32'h0000_0000);
        tick();
        csr_op = 2'b00; trap_valid = 1'b0;
        check_eq("trap_epc", epc, 32'h0000_1004);
        rd_chk("trap_mepc", 12'h341, 32'h0000_1004);
        rd_chk("trap_mcause", 12'h342, 32'h0000_000B);
        rd_chk("trap_mtval", 12'h343, 32'hDEAD_BEEF);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);

        // mret with a simultaneous mscratch write: mret wins
        csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'h0000_0000; mret = 1'b1;
        tick();
        csr_op = 2'b00; mret = 1'b0;
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        rd_chk("mret_mscratch", 12'h340, 32'hF0F0_F00F);

        // Illegal accesses
        csr_addr = 12'hF14; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF;
        #1 check_eq("ill_mhartid", {31'h0, illegal_csr}, 32'h1);
        tick();
        csr_addr = 12'h7C0; csr_op = 2'b10; csr_wdata = 32'hFFFF_FFFF;
        #1 check_eq("ill_7c0", {31'h0, illegal_csr}, 32'h1);
        tick();
        csr_op = 2'b00;
        rd_chk("mhartid_rd", 12'hF14, 32'h0000_0000);
        check_eq("mhartid_rd_legal", {31'h0, illegal_csr}, 32'h0);
        rd_chk("unimpl_rd", 12'h7C0, 32'h0000_0000);

        // mepc alignment on software write
        csr_acc(12'h341, 2'b01, 32'h0000_1003);
        check_eq("mepc_wr_epc", epc, 32'h0000_1000);

`ifdef CSR_COUNTERS_EN
        // mcycle wrap
        csr_acc(12'hB80, 2'b01, 32'hFFFF_FFFF);
        csr_acc(12'hB00, 2'b01, 32'hFFFF_FFFF);
        rd_chk("mcycle_lo_ones", 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd_chk("mcycle_lo_wrap", 12'hB00, 32'h0000_0000);
        rd_chk("mcycle_hi_wrap", 12'hB80, 32'h0000_0000);
        // minstret counts retire strobes
        csr_acc(12'hB82, 2'b01, 32'h0000_0000);
        csr_acc(12'hB02, 2'b01, 32'h0000_0000);
        rd_chk("minstret_zero", 12'hB02, 32'h0000_0000);
        instr_retire = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        instr_retire = 1'b0;
        rd_chk("minstret_3", 12'hB02, 32'h0000_0003);
        tick();
        rd_chk("minstret_hold", 12'hB02, 32'h0000_0003);
        // write replaces increment
        csr_acc(12'hB00, 2'b01, 32'h0000_0005);
        rd_chk("mcycle_wr5", 12'hB00, 32'h0000_0005);
        tick();
        rd_chk("mcycle_inc6", 12'hB00, 32'h0000_0006);
`else
        csr_addr = 12'hB00; csr_op = 2'b01; csr_wdata = 32'h0000_0005;
        #1 check_eq("ill_mcycle", {31'h0, illegal_csr}, 32'h1);
        tick();
        csr_addr = 12'hB82; csr_op = 2'b11;
        #1 check_eq("ill_minstreth", {31'h0, illegal_csr}, 32'h1);
        tick();
        rd_chk("mcycle_rd0", 12'hB00, 32'h0000_0000);
`endif

        // Asynchronous reset in the middle of a pending trap
        trap_valid = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 32'h0000_0005;
        trap_val = 32'h1111_1111;
        #10 rst_n = 1'b0;
        #1;
        check_eq("arst_epc", epc, 32'h0000_0000);
        check_eq("arst_trap_vector", trap_vector, 32'h0000_0000);
        rd_chk("arst_mepc", 12'h341, 32'h0000_0000);
        check_eq("arst_illegal", {31'h0, illegal_csr}, 32'h0);
        rd_chk("arst_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("arst_mscratch", 12'h340, 32'h0000_0000);
        rd_chk("arst_mcause", 12'h342, 32'h0000_0000);
        rd_chk("arst_mie", 12'h304, 32'h0000_0000);
        tick();
        check_eq("arst_hold_epc", epc, 32'h0000_0000);
        trap_valid = 1'b0;
        #5 rst_n = 1'b1;
        tick();
        check_eq("post_rst_epc", epc, 32'h0000_0000);
        rd_chk("post_rst_mtval", 12'h343, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 MTVEC_RESET, 32'h0000_0000, mtvec value loaded at reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 csr_addr  input  12  CSR address of current instruction.
REQ-005 csr_wdata  input  32  operand from CSR source mux (rs1 value or zimm).
REQ-006 csr_op  input  2  00 none, 01 write, 10 set, 11 clear.
REQ-007 csr_rdata  output  32  current value of addressed CSR (pre-write).
REQ-008 illegal_csr  output  1  access to unimplemented or read-only-written CSR.
REQ-009 trap_valid  input  1  trap entry this cycle.
REQ-010 trap_cause  input  32  value for mcause.
REQ-011 trap_pc  input  32  faulting PC for mepc.
REQ-012 trap_val  input  32  value for mtval.
REQ-013 mret  input  1  mret retires this cycle.
REQ-014 instr_retire  input  1  one instruction retires this cycle.
REQ-015 trap_vector  output  32  {mtvec[31:2],2'b00}.
REQ-016 epc  output  32  current mepc.

Function
REQ-017 Implemented: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mhartid 0xF14 (read-only, reads 0).
REQ-018 csr_rdata SHALL be combinational from csr_addr; unimplemented addresses read 0.
REQ-019 New value: write = wdata; set = old | wdata; clear = old & ~wdata; committed at next rising clk edge, visible on csr_rdata the following cycle.
REQ-020 illegal_csr SHALL assert combinationally when csr_op != 00 and address unimplemented or address is mhartid; no state changes when illegal_csr=1.
REQ-021 mstatus SHALL store only MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; all other bits read 0 and ignore writes.
REQ-022 mtvec[1:0] and mepc[1:0] SHALL always read 0 (direct mode, aligned).
REQ-023 Trap entry (trap_valid=1): mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_val, MPIE<=MIE, MIE<=0.
REQ-024 mret=1: MIE<=MPIE, MPIE<=1.
REQ-025 Priority in same cycle: trap_valid > mret > CSR write; lower-priority actions are discarded entirely.
REQ-026 epc and trap_vector SHALL reflect registered values (same-cycle writes not bypassed).

Reset
REQ-027 On rst_n=0, asynchronously: mstatus MIE=0, MPIE=0; mtvec<=MTVEC_RESET&~3; mie, mscratch, mepc, mcause, mtval <= 0; counters <= 0.
REQ-028 Reset asserted mid-operation SHALL override any pending trap, mret, write or count in that cycle.
REQ-029 After reset: csr_rdata=0 for address 0x341, illegal_csr=0 when csr_op=00, trap_vector=MTVEC_RESET&~3.

Configuration
REQ-030 Macro CSR_COUNTERS_EN defined: 64-bit mcycle (0xB00 low, 0xB80 high) and minstret (0xB02, 0xB82) implemented and writable.
REQ-031 mcycle SHALL increment by 1 every cycle; minstret by 1 when instr_retire=1; both wrap 2^64-1 -> 0.
REQ-032 A CSR write to any half of a counter that cycle SHALL replace the increment for that counter (written value loaded, not incremented).
REQ-033 Macro undefined: no counter flops; 0xB00/0xB80/0xB02/0xB82 unimplemented (read 0, illegal_csr on access).

Verification
REQ-034 Write 0x305 with 0x8000_0103 -> next cycle csr_rdata=0x8000_0100, trap_vector=0x8000_0100.
REQ-035 mscratch=0xF0F0_F0F0, set 0x0000_000F then clear 0x0000_00F0 -> reads 0xF0F0_F0FF then 0xF0F0_F00F.
REQ-036 MIE=1, trap_valid with trap_pc=0x0000_1006, cause=0xB, simultaneous write to mepc -> mepc=0x0000_1004, mcause=0xB, mstatus=0x0000_1880; then mret -> mstatus=0x0000_1888.
REQ-037 Write 0xF14 or 0x7C0 -> illegal_csr=1, no register changes.
REQ-038 CSR_COUNTERS_EN: mcycle high=0xFFFF_FFFF, low=0xFFFF_FFFF -> next cycle both read 0; instr_retire held 3 cycles from 0 -> minstret=3; write mcycle low with 5 -> reads 5 next cycle, 6 after.
REQ-039 Assert rst_n low asynchronously mid-trap -> all REQ-027 values immediately, trap discarded.
